// File: rtl/abs_diff_sad_sched.sv
// Round-robin scheduler that shares one external 3-bit |a-b| unit between NREQ requesters
// and accumulates a saturating per-requester SAD, one result per burst via valid/ready.
module abs_diff_sad_sched #(
    parameter int NREQ  = 2,
    parameter int ACC_W = 8,
    parameter int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [3*NREQ-1:0] req_a,
    input  logic [3*NREQ-1:0] req_b,
    input  logic [NREQ-1:0]   req_last,
    output logic [2:0]        ad_a,
    output logic [2:0]        ad_b,
    input  logic [2:0]        ad_diff,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [IDW-1:0]    res_id,
    output logic [ACC_W-1:0]  res_sad,
    output logic              res_sat
);

    logic [ACC_W-1:0] acc [NREQ];
    logic [NREQ-1:0]  sat;
    logic             s1_valid;
    logic             s1_last;
    logic [IDW-1:0]   s1_id;
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   gnt_id;
    logic [IDW-1:0]   rr_next;
    logic             any_grant;
    logic             stall;
    logic             complete;
    logic [2:0]       sel_a;
    logic [2:0]       sel_b;
    logic             sel_last;
    logic [ACC_W:0]   sum;
    logic             ovf;
    logic [ACC_W-1:0] clamped;

    // A last pair cannot retire while the previous result is still unconsumed.
    assign stall    = s1_valid & s1_last & res_valid & ~res_ready;
    assign complete = s1_valid & s1_last & ~stall;

    always_comb begin
        int k;
        k         = 0;
        req_ready = '0;
        any_grant = 1'b0;
        gnt_id    = '0;
        sel_a     = '0;
        sel_b     = '0;
        sel_last  = 1'b0;
        for (int j = 0; j < NREQ; j++) begin
            k = int'(rr_ptr) + j;
            if (k >= NREQ) begin
                k = k - NREQ;
            end
            if (!any_grant && !stall && req_valid[k]) begin
                any_grant    = 1'b1;
                req_ready[k] = 1'b1;
                gnt_id       = IDW'(k);
                sel_a        = req_a[3*k +: 3];
                sel_b        = req_b[3*k +: 3];
                sel_last     = req_last[k];
            end
        end
    end

    assign rr_next = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);

    assign sum     = {1'b0, acc[s1_id]} + {{(ACC_W-2){1'b0}}, ad_diff};
    assign ovf     = sum[ACC_W];
    assign clamped = ovf ? {ACC_W{1'b1}} : sum[ACC_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREQ; i++) begin
                acc[i] <= '0;
            end
            sat       <= '0;
            s1_valid  <= 1'b0;
            s1_last   <= 1'b0;
            s1_id     <= '0;
            rr_ptr    <= '0;
            ad_a      <= '0;
            ad_b      <= '0;
            res_valid <= 1'b0;
            res_id    <= '0;
            res_sad   <= '0;
            res_sat   <= 1'b0;
        end else begin
            if (!stall) begin
                s1_valid <= any_grant;
                if (any_grant) begin
                    ad_a    <= sel_a;
                    ad_b    <= sel_b;
                    s1_id   <= gnt_id;
                    s1_last <= sel_last;
                    rr_ptr  <= rr_next;
                end
                if (s1_valid && !s1_last) begin
                    acc[s1_id] <= clamped;
                    if (ovf) begin
                        sat[s1_id] <= 1'b1;
                    end
                end
            end
            if (complete) begin
                res_sad    <= clamped;
                res_id     <= s1_id;
                res_sat    <= sat[s1_id] | ovf;
                res_valid  <= 1'b1;
                acc[s1_id] <= '0;
                sat[s1_id] <= 1'b0;
            end else if (res_valid && res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_abs_diff_sad_sched.sv
// Scoreboard bench: two instances (ACC_W=8 and ACC_W=4) share stimulus; a burst-level
// model pushes expected results on each accepted last pair, a monitor pops on handshake.
module tb_abs_diff_sad_sched;

    typedef struct packed {
        logic       vld;
        logic [2:0] a;
        logic [2:0] b;
        logic       last;
    } ent_t;

    typedef struct packed {
        logic       id;
        logic [7:0] sad8;
        logic       sat8;
        logic [3:0] sad4;
        logic       sat4;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [1:0] req_valid;
    logic [5:0] req_a;
    logic [5:0] req_b;
    logic [1:0] req_last;
    logic       res_ready;

    logic [1:0] req_ready8, req_ready4;
    logic [2:0] ad_a8, ad_b8, ad_diff8, ad_a4, ad_b4, ad_diff4;
    logic       res_valid8, res_valid4, res_id8, res_id4, res_sat8, res_sat4;
    logic [7:0] res_sad8;
    logic [3:0] res_sad4;

    assign ad_diff8 = (ad_a8 > ad_b8) ? ad_a8 - ad_b8 : ad_b8 - ad_a8;
    assign ad_diff4 = (ad_a4 > ad_b4) ? ad_a4 - ad_b4 : ad_b4 - ad_a4;

    abs_diff_sad_sched #(.NREQ(2), .ACC_W(8)) dut8 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready8),
        .req_a(req_a), .req_b(req_b), .req_last(req_last),
        .ad_a(ad_a8), .ad_b(ad_b8), .ad_diff(ad_diff8),
        .res_valid(res_valid8), .res_ready(res_ready), .res_id(res_id8),
        .res_sad(res_sad8), .res_sat(res_sat8)
    );

    abs_diff_sad_sched #(.NREQ(2), .ACC_W(4)) dut4 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready4),
        .req_a(req_a), .req_b(req_b), .req_last(req_last),
        .ad_a(ad_a4), .ad_b(ad_b4), .ad_diff(ad_diff4),
        .res_valid(res_valid4), .res_ready(res_ready), .res_id(res_id4),
        .res_sad(res_sad4), .res_sat(res_sat4)
    );

    ent_t rq [2][$];
    ent_t cur [2];
    bit   pres [2];
    exp_t exp_q [$];
    int   macc [2];
    int   rr_m;
    int   cyc;
    int   first_acc, first_rv;
    bit   prev_rv, hold, res_rand;
    exp_t h_val;
    int   n_chk, n_fail;

    task automatic chk(string nm, int act, int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    task automatic put(int i, bit v, int a, int b, bit l);
        ent_t e;
        e.vld  = v;
        e.a    = 3'(a);
        e.b    = 3'(b);
        e.last = l;
        rq[i].push_back(e);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst       = 1'b1;
        req_valid = '0;
        for (int i = 0; i < 2; i++) begin
            rq[i].delete();
            pres[i] = 1'b0;
            macc[i] = 0;
        end
        exp_q.delete();
        rr_m      = 0;
        hold      = 1'b0;
        prev_rv   = 1'b0;
        first_acc = -1;
        first_rv  = -1;
        #1;
        chk("reset_out8", int'({res_valid8, res_id8, res_sad8, res_sat8, ad_a8, ad_b8, req_ready8}), 0);
        chk("reset_out4", int'({res_valid4, res_id4, res_sad4, res_sat4, ad_a4, ad_b4, req_ready4}), 0);
        rst = 1'b0;
    endtask

    task automatic wait_idle(string nm);
        int n;
        n = 0;
        while ((rq[0].size() != 0 || rq[1].size() != 0 || exp_q.size() != 0 || res_valid8) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_done_in_time"}, int'(n < 5000), 1);
        @(negedge clk);
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Driver: presents queue heads, models acceptance and the round-robin choice.
    initial begin
        bit [1:0] acc_m;
        int w, d;
        exp_t e;
        forever begin
            @(negedge clk);
            acc_m = '0;
            if (!rst) begin
                chk("ready_match", int'(req_ready4), int'(req_ready8));
                if (req_ready8 != 2'b00) begin
                    w = req_valid[rr_m] ? rr_m : 1 - rr_m;
                    chk("rr_grant", int'(req_ready8), 1 << w);
                    rr_m = (w == 0) ? 1 : 0;
                end
                for (int i = 0; i < 2; i++) begin
                    if (pres[i] && req_valid[i] && req_ready8[i]) begin
                        acc_m[i] = 1'b1;
                        if (first_acc < 0) first_acc = cyc + 1;
                        d = (cur[i].a > cur[i].b) ? cur[i].a - cur[i].b : cur[i].b - cur[i].a;
                        macc[i] += d;
                        if (cur[i].last) begin
                            e.id   = 1'(i);
                            e.sad8 = 8'((macc[i] > 255) ? 255 : macc[i]);
                            e.sat8 = (macc[i] > 255);
                            e.sad4 = 4'((macc[i] > 15) ? 15 : macc[i]);
                            e.sat4 = (macc[i] > 15);
                            exp_q.push_back(e);
                            macc[i] = 0;
                        end
                    end
                end
            end
            @(posedge clk);
            #1;
            if (res_rand) res_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 2; i++) begin
                if (pres[i] && (!cur[i].vld || acc_m[i])) void'(rq[i].pop_front());
                if (rq[i].size() != 0) begin
                    pres[i]          = 1'b1;
                    cur[i]           = rq[i][0];
                    req_valid[i]     = cur[i].vld;
                    req_a[3*i +: 3]  = cur[i].a;
                    req_b[3*i +: 3]  = cur[i].b;
                    req_last[i]      = cur[i].last;
                end else begin
                    pres[i]      = 1'b0;
                    req_valid[i] = 1'b0;
                end
            end
        end
    end

    // Monitor: pops the scoreboard on every result handshake and checks hold stability.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (hold) begin
                chk("hold_valid", int'(res_valid8), 1);
                chk("hold_id", int'(res_id8), int'(h_val.id));
                chk("hold_sad", int'(res_sad8), int'(h_val.sad8));
                chk("hold_sat", int'(res_sat8), int'(h_val.sat8));
            end
            if (res_valid8 && !prev_rv && first_rv < 0) first_rv = cyc;
            prev_rv = res_valid8;
            chk("valid_match", int'(res_valid4), int'(res_valid8));
            if (res_valid8 && res_ready) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL res_unexpected: got id=%0d sad=%0d, no result expected", res_id8, res_sad8);
                end else begin
                    e = exp_q.pop_front();
                    chk("res_id8", int'(res_id8), int'(e.id));
                    chk("res_sad8", int'(res_sad8), int'(e.sad8));
                    chk("res_sat8", int'(res_sat8), int'(e.sat8));
                    chk("res_id4", int'(res_id4), int'(e.id));
                    chk("res_sad4", int'(res_sad4), int'(e.sad4));
                    chk("res_sat4", int'(res_sat4), int'(e.sat4));
                end
            end
            hold      = res_valid8 && !res_ready;
            h_val.id  = res_id8;
            h_val.sad8 = res_sad8;
            h_val.sat8 = res_sat8;
        end
    end

    initial begin
        n_chk     = 0;
        n_fail    = 0;
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_last  = '0;
        res_ready = 1'b1;
        res_rand  = 1'b0;
        rr_m      = 0;
        hold      = 1'b0;
        prev_rv   = 1'b0;
        pres[0]   = 1'b0;
        pres[1]   = 1'b0;
        macc[0]   = 0;
        macc[1]   = 0;
        first_acc = -1;
        first_rv  = -1;

        // T1: single requester, SAD 3+5+0 = 8, result 3 edges after first grant
        do_reset();
        put(0, 1, 5, 2, 0);
        put(0, 1, 1, 6, 0);
        put(0, 1, 7, 7, 1);
        wait_idle("t1");
        chk("t1_latency", first_rv - first_acc, 3);

        // T2: both busy every cycle, 4x (7,0) each -> 28 (15 saturated on ACC_W=4)
        do_reset();
        for (int n = 0; n < 4; n++) begin
            put(0, 1, 7, 0, n == 3);
            put(1, 1, 7, 0, n == 3);
        end
        wait_idle("t2");

        // T3: 21 saturates the narrow instance; the next burst starts clean
        do_reset();
        for (int n = 0; n < 3; n++) put(0, 1, 7, 0, n == 2);
        put(0, 1, 1, 0, 1);
        wait_idle("t3");

        // T4: pending result blocks a second last pair and all further grants
        do_reset();
        res_ready = 1'b0;
        put(0, 1, 2, 5, 1);
        for (int n = 0; n < 4; n++) put(0, 0, 0, 0, 0);
        put(0, 1, 1, 4, 0);
        put(0, 1, 6, 6, 1);
        for (int n = 0; n < 3; n++) put(1, 0, 0, 0, 0);
        put(1, 1, 6, 1, 1);
        repeat (10) @(negedge clk);
        chk("t4_pending", int'(res_valid8), 1);
        chk("t4_valid_waiting", int'(req_valid != 2'b00), 1);
        chk("t4_no_grant", int'(req_ready8), 0);
        @(posedge clk);
        #1;
        res_ready = 1'b1;
        wait_idle("t4");

        // T5: reset mid-burst discards the partial sum of 3+4
        do_reset();
        put(0, 1, 4, 1, 0);
        put(0, 1, 6, 2, 0);
        begin
            int n;
            n = 0;
            while ((rq[0].size() != 0) && n < 100) begin
                @(negedge clk);
                n++;
            end
        end
        repeat (2) @(negedge clk);
        do_reset();
        put(0, 1, 3, 1, 1);
        wait_idle("t5");

        // T6: one-pair bursts alternating between requesters
        do_reset();
        for (int n = 0; n < 6; n++) begin
            put(0, 1, n, 7 - n, 1);
            put(0, 0, 0, 0, 0);
            put(1, 0, 0, 0, 0);
            put(1, 1, (n * 3) % 8, n, 1);
        end
        wait_idle("t6");

        // Random traffic with random back-pressure
        do_reset();
        res_rand = 1'b1;
        for (int i = 0; i < 2; i++) begin
            for (int n = 0; n < 150; n++) begin
                if ($urandom_range(0, 2) == 0) put(i, 0, 0, 0, 0);
                put(i, 1, $urandom_range(0, 7), $urandom_range(0, 7),
                    ($urandom_range(0, 5) == 0) || (n == 149));
            end
        end
        wait_idle("rand");
        res_rand  = 1'b0;
        res_ready = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
